aud_data_in: RTL and testbench

Audio capture path: receives the codec ADC serial stream (I2S, MSB-first, one-bit delay after word-select change) and deserializes the 16-bit left-channel samples. Each sample goes into an on-chip sample FIFO, which the processor side drains with a read/valid handshake. It is the receive-side counterpart of the audio output buffer and shares its sample width and buffer depth.

---
 rtl/aud_pkg.sv | 15 +
 rtl/aud_fifo.sv | 76 +++++++
 rtl/aud_data_in.sv | 95 +++++++++
 tb/tb_aud_data_in.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared constants and types for the audio capture path.
// Sample width and depth match the audio output buffer.
package aud_pkg;

  localparam int AUD_DATA_W     = 16;
  localparam int AUD_FIFO_DEPTH = 2048;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PUSH,
    WAIT
  } aud_rx_state_t;

endpackage

// File: rtl/aud_fifo.sv
// Single-clock sample FIFO with a registered read port (block-RAM friendly).
// Occupancy is kept in its own counter; the pointers simply wrap.
module aud_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2048,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_empty,
  output logic              o_full,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              w_wr;
  logic              w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign w_wr    = i_wr_en & ~o_full;
  assign w_rd    = i_rd_en & ~o_empty;

  // NOTE: the storage array has no reset so it maps onto block RAM; reset only
  // clears the pointers and count, which is enough to make its contents stale.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A push against a full FIFO is lost even if a pop frees a slot this cycle.
      if (i_wr_en && o_full) r_overflow <= 1'b1;
    end
  end

  assign o_rd_data  = r_rd_data;
  assign o_rd_valid = r_rd_valid;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/aud_data_in.sv
// I2S receiver: deserializes left-channel ADC words and queues them in aud_fifo.
// Right-channel words and any bits past the 16th of a left word are ignored.
module aud_data_in
  import aud_pkg::*;
#(
  parameter int DATA_W = AUD_DATA_W,
  parameter int DEPTH  = AUD_FIFO_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              lrclk,
  input  logic              sdata,
  input  logic              read,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              new_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  localparam int                BC_W     = $clog2(DATA_W);
  localparam logic [BC_W-1:0]   LAST_BIT = BC_W'(DATA_W - 1);

  aud_rx_state_t     r_state;
  aud_rx_state_t     w_next_state;
  logic              r_lr_prev;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              w_left_start;
  logic              w_push;

  // The bit on the right-to-left edge is the I2S delay slot, never data.
  assign w_left_start = bit_en & r_lr_prev & ~lrclk;
  assign w_push       = (r_state == PUSH);
  assign new_data     = w_push;

  always_ff @(posedge clk) begin
    if (rst) r_lr_prev <= 1'b1;
    else if (bit_en) r_lr_prev <= lrclk;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next_state;
  end

  always_comb begin
    // NOTE: assign the default first so every path drives the signal and no
    // latch is inferred.
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_left_start) w_next_state = SHIFT;
      SHIFT:   if (!w_left_start && bit_en && r_bit_cnt == LAST_BIT) w_next_state = PUSH;
      PUSH:    w_next_state = WAIT;
      WAIT:    if (w_left_start) w_next_state = SHIFT;
      default: w_next_state = IDLE;
    endcase
  end

  // A left-word start inside SHIFT drops the partial word and begins afresh.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_left_start && r_state != PUSH) begin
      r_bit_cnt <= '0;
    end else if (bit_en && r_state == SHIFT) begin
      r_shift   <= {r_shift[DATA_W-2:0], sdata};
      r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  aud_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_push),
    .i_wr_data  (r_shift),
    .i_rd_en    (read),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid),
    .o_empty    (empty),
    .o_full     (full),
    .o_count    (count),
    .o_overflow (overflow)
  );

endmodule

// File: tb/tb_aud_data_in.sv
// Directed bench for aud_data_in: inputs change and outputs are checked on the
// falling clock edge, so the DUT always samples settled values on the rising edge.
module tb_aud_data_in;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 2048;
  localparam int CNT_W  = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              bit_en;
  logic              lrclk;
  logic              sdata;
  logic              read;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              new_data;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  int n_cmp = 0;
  int n_err = 0;
  int nd_cnt = 0;

  always #5 clk = ~clk;

  aud_data_in dut (
    .clk      (clk),
    .rst      (rst),
    .bit_en   (bit_en),
    .lrclk    (lrclk),
    .sdata    (sdata),
    .read     (read),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .new_data (new_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overflow (overflow)
  );

  always @(posedge clk) if (new_data) nd_cnt <= nd_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want run to complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic lr, input logic d);
    bit_en = 1'b1;
    lrclk  = lr;
    sdata  = d;
    @(negedge clk);
    bit_en = 1'b0;
  endtask

  // Compact frame: delay slot + 16 left bits, then one right-channel bit.
  // With rd_in_push, read is raised during the PUSH cycle of this word.
  task automatic send_frame(input logic [15:0] w, input bit rd_in_push);
    send_bit(1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) send_bit(1'b0, w[i]);
    if (rd_in_push) read = 1'b1;
    send_bit(1'b1, 1'b0);
    read = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [15:0] exp);
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int nd0;
    logic [15:0] right_word;
    rst = 1'b1; bit_en = 1'b0; lrclk = 1'b1; sdata = 1'b0; read = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_new_data", 32'(new_data), 32'd0);
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Single frame with a full right word that must not be captured
    nd0 = nd_cnt;
    right_word = 16'hFFFF;
    send_bit(1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) send_bit(1'b0, right_word[i] ^ 1'b1 ^ (16'hA5C3 >> i) & 1'b1 ^ 1'b1 ^ 1'b1);
    send_bit(1'b1, 1'b0);
    for (int i = 15; i >= 0; i--) send_bit(1'b1, right_word[i]);
    repeat (2) @(negedge clk);
    check("single_pulses", 32'(nd_cnt - nd0), 32'd1);
    check("single_count",  32'(count), 32'd1);
    do_read("single_rd", 16'hA5C3);
    check("single_empty", 32'(empty), 32'd1);
    @(negedge clk);
    check("single_valid_drop", 32'(rd_valid), 32'd0);

    // Read while empty is ignored
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    check("empty_rd_valid", 32'(rd_valid), 32'd0);
    check("empty_rd_hold",  32'(rd_data),  32'hA5C3);

    // Short word: 10 bits, then a fresh start and a full word
    nd0 = nd_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_frame(16'h1234, 1'b0);
    @(negedge clk);
    check("short_pulses", 32'(nd_cnt - nd0), 32'd1);
    check("short_count",  32'(count), 32'd1);
    do_read("short_rd", 16'h1234);

    // Fill to full, then one more word overflows
    for (int i = 1; i <= DEPTH; i++) send_frame(16'(i), 1'b0);
    @(negedge clk);
    check("fill_full",     32'(full),     32'd1);
    check("fill_count",    32'(count),    32'd2048);
    check("fill_overflow", 32'(overflow), 32'd0);
    nd0 = nd_cnt;
    send_frame(16'd2049, 1'b0);
    @(negedge clk);
    check("ovf_pulse", 32'(nd_cnt - nd0), 32'd1);
    check("ovf_flag",  32'(overflow),     32'd1);
    check("ovf_count", 32'(count),        32'd2048);

    // Drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      read = 1'b1;
      @(negedge clk);
      read = 1'b0;
      check("drain_data", 32'(rd_data), 32'(i));
    end
    check("drain_last",     32'(rd_data),  32'h0800);
    check("drain_empty",    32'(empty),    32'd1);
    check("drain_overflow", 32'(overflow), 32'd1);

    // Concurrent push and pop at count 5
    for (int i = 0; i < 5; i++) send_frame(16'h0010 + 16'(i), 1'b0);
    check("conc_pre_count", 32'(count), 32'd5);
    send_frame(16'h0015, 1'b1);
    check("conc_count", 32'(count),    32'd5);
    check("conc_valid", 32'(rd_valid), 32'd1);
    check("conc_data",  32'(rd_data),  32'h0010);

    // Reset mid-word
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lrclk = 1'b1;
    @(negedge clk);
    check("mrst_count",    32'(count),    32'd0);
    check("mrst_empty",    32'(empty),    32'd1);
    check("mrst_overflow", 32'(overflow), 32'd0);
    check("mrst_rd_data",  32'(rd_data),  32'd0);
    send_frame(16'hBEEF, 1'b0);
    @(negedge clk);
    check("mrst_new_count", 32'(count), 32'd1);
    do_read("mrst_rd", 16'hBEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
